fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Fetch stage directly downstream of the program counter logic in the RISC_V core.
- Owns a fetch PC and issues in-order word requests to instruction memory with valid/ready on the request side.
- Buffers returned instructions, each paired with its PC, in a small FIFO that feeds decode through a valid/ready handshake.
- Handles taken-branch/jump redirects (PCSrc/PCTarget from execute) by flushing the buffer and discarding in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and also the cap on (occupancy + outstanding requests); power of two, minimum 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- redirect_valid  input  1  PCSrc from execute; a redirect is taken this cycle.
- redirect_pc  input  32  PCTarget; bits [1:0] are ignored and treated as 0.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  word-aligned fetch address, equal to fetch_pc.
- imem_req_ready  input  1  memory accepts the request.
- imem_resp_valid  input  1  instruction returned; in order, no backpressure.
- imem_resp_data  input  32  returned instruction word.
- instr_valid  output  1  FIFO head valid toward decode.
- instr_data  output  32  FIFO head instruction.
- instr_pc  output  32  PC of the FIFO head instruction.
- instr_ready  input  1  decode consumes the head.

Behaviour:
- Reset, applied for one or more cycles:
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0.
  - instr_valid = 0; imem_req_valid = 0 while reset is high.
  - Responses arriving while reset is high are discarded.
- State:
  - fetch_pc: 32 bits.
  - outstanding: accepted requests with no response yet; width clog2(DEPTH)+1.
  - drop_cnt: stale responses still to be discarded; same width.
  - FIFO of {pc, instr}.
- Request issue:
  - imem_req_valid = !reset && !redirect_valid && (fifo_count + outstanding < DEPTH).
  - A request is accepted when imem_req_valid && imem_req_ready. On acceptance: fetch_pc += 4 (wraps modulo 2^32), outstanding += 1.
  - imem_req_addr is stable while imem_req_valid is high and the request is not yet accepted.
- Response:
  - On imem_resp_valid, outstanding -= 1.
  - If drop_cnt > 0, the response is discarded and drop_cnt -= 1.
  - Otherwise push {resp_pc, imem_resp_data}. resp_pc comes from a separate response-PC register that advances by 4 on each kept response and is loaded on redirect/reset.
  - The credit rule guarantees the FIFO never overflows on a push.
- Decode side:
  - The head is registered; the earliest instr_valid is the cycle after the response.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leave the count unchanged; push into an empty FIFO with instr_ready high still shows the new entry only from the next cycle.
  - instr_data and instr_pc hold while instr_valid && !instr_ready.
- Redirect, when redirect_valid = 1 in cycle N:
  - FIFO cleared at the end of N; instr_valid = 0 in N+1.
  - fetch_pc and the response-PC register are loaded with {redirect_pc[31:2], 2'b00}.
  - drop_cnt = outstanding after N's response update (a response arriving in N is itself discarded).
  - No request is issued in N.
  - A pop in N is ignored; decode must squash via its own PCSrc path.
  - A redirect while drop_cnt > 0 accumulates correctly, because drop_cnt is loaded from the total outstanding.
  - Back-to-back redirects: the last one wins.
- Throughput: one instruction per cycle sustained when memory has 1-cycle latency, imem_req_ready = 1 and instr_ready = 1.
- Protocol violation: a response with outstanding = 0 is an error; the bench must check for it. RTL behaviour in that case is undefined.

Decomposition:
- Package fetch_pkg:
  - XLEN = 32, INSTR_BYTES = 4.
  - typedef fetch_entry_t = struct packed {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module sync_fifo:
  - Parameterised on entry type and depth.
  - Synchronous active-high clear/flush; ports push, pop, full, empty, count, head.
  - fetch_buffer instantiates it once; credit and redirect logic stay at top level.

Test Plan:
- Reset with RESET_PC = 0, memory latency 1, always ready, instr_ready = 1 → requests to 0x0, 0x4, 0x8…; decode sees instr_pc 0x0, 0x4, 0x8 on consecutive cycles from cycle 3 after reset release.
- instr_ready = 0 and 10 cycles elapse with latency 1 → exactly 4 requests issued, FIFO full, imem_req_valid = 0; raise instr_ready → entries 0x0..0xC delivered in order, and fetching resumes at 0x10.
- Latency 3, redirect to 0x100 while 2 requests are outstanding → the 2 stale responses are dropped; the next delivered instr_pc = 0x100 with the data memory returned for 0x100.
- Redirect to 0x203 in the same cycle as a response arrives and a pop occurs → responding entry discarded, fetch restarts at 0x200, instr_valid = 0 in the next cycle.
- Fetch near 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Reset asserted mid-stream with 3 requests outstanding → all outputs return to their reset values; responses during reset are ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  // One buffered fetch result: the instruction word and the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered storage and a synchronous clear.
// Latency: a pushed entry appears at the head from the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; clear wins over both.
module sync_fifo #(
  parameter type T     = logic [63:0],
  parameter int  DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  T                       i_push_dat,
  input  logic                   i_pop,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output T                       o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Entry storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; clear wins over any same-cycle push or pop.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: issues in-order word requests and buffers {pc, instr} for decode.
// Latency: response to instr_valid is one cycle; 1 instr/cycle with 1-cycle memory.
// Backpressure: requests throttled so buffered + outstanding never exceeds DEPTH.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]      CREDIT_CAP = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(INSTR_BYTES);

  // Next PC to request, and PC to attach to the next kept response.
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  // Accepted requests still awaiting data, and how many of those are stale.
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_fifo_count;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [CW:0]     w_credit_used;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_req_fire;
  logic            w_resp;
  logic            w_keep;
  logic            w_pop;
  logic            w_fifo_clr;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

  assign w_redirect_pc = align_pc(redirect_pc);

  // Every buffered entry and every in-flight request holds a slot; a response
  // can therefore always be pushed without the FIFO pushing back on memory.
  assign w_credit_used  = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign imem_req_valid = !reset && !redirect_valid && !w_fifo_full &&
                          (w_credit_used < CREDIT_CAP);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response arriving during reset or a redirect belongs to a dead stream.
  assign w_resp = imem_resp_valid && !reset;
  assign w_keep = w_resp && (r_drop_cnt == '0) && !redirect_valid;

  assign w_push_entry.pc    = r_resp_pc;
  assign w_push_entry.instr = imem_resp_data;

  // Decode squashes through its own path on a redirect, so a pop then is moot.
  assign instr_valid = !reset && !w_fifo_empty;
  assign instr_data  = w_head.instr;
  assign instr_pc    = w_head.pc;
  assign w_pop       = instr_valid && instr_ready && !redirect_valid;
  assign w_fifo_clr  = reset || redirect_valid;

  sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (clk),
    .i_clr      (w_fifo_clr),
    .i_push     (w_keep),
    .i_push_dat (w_push_entry),
    .i_pop      (w_pop),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count),
    .o_head     (w_head)
  );

  // In-flight count after this cycle's request acceptance and response arrival.
  always_comb begin
    w_outstanding_nxt = r_outstanding;
    case ({w_req_fire, w_resp})
      2'b10: w_outstanding_nxt = r_outstanding + 1'b1;
      2'b01: begin
        if (r_outstanding != '0) begin
          w_outstanding_nxt = r_outstanding - 1'b1;
        end
      end
      default: w_outstanding_nxt = r_outstanding;
    endcase
  end

  // Request-side PC: restart on reset/redirect, step one word per accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
    end else if (w_req_fire) begin
      r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

  // Response-side PC: tracks the address of the next response that will be kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_resp_pc <= w_redirect_pc;
    end else if (w_keep) begin
      r_resp_pc <= r_resp_pc + PC_STEP;
    end
  end

  // Credit tracking; on redirect every request still in flight becomes stale,
  // which also covers stale ones left over from an earlier redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (redirect_valid) begin
        r_drop_cnt <= w_outstanding_nxt;
      end else if (w_resp && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomised and directed bench for fetch_buffer with a memory model and scoreboard.
// Latency: memory latency is configurable per phase, with optional random jitter.
// Backpressure: imem_req_ready and instr_ready are driven by directed or random patterns.
module tb_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  fetch_buffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_data      (instr_data),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit jitter = 1'b0;

  // Reference model: memory requests in flight, expected decode stream, stream epoch.
  req_t        pending[$];
  exp_t        expq[$];
  logic [31:0] acc_log[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_resp_pc = RESET_PC;
  int          m_occ = 0;
  int          epoch = 0;
  int          n_acc = 0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_pc, prev_data;
  exp_t        mon_e;
  int          ob_cnt = 0;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check request/valid side, advance the model.
  task automatic step(input bit rst, input bit redir, input logic [31:0] tgt,
                      input bit rdy, input bit ir);
    bit   resp_now;
    bit   exp_rv;
    int   pre_occ;
    req_t r;
    @(posedge clk);
    #1;
    cyc++;
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_req_ready = rdy;
    instr_ready    = ir;
    resp_now = (pending.size() > 0) && (pending[0].due <= cyc) &&
               (!jitter || ($urandom_range(0, 2) != 0));
    imem_resp_valid = resp_now;
    imem_resp_data  = resp_now ? memf(pending[0].addr) : $urandom();
    #1;
    exp_rv = !rst && !redir && (m_occ + pending.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("instr_valid", 32'(instr_valid), 32'(!rst && (m_occ > 0)));
    if (imem_req_valid && rdy) chk("req_addr", imem_req_addr, m_fetch_pc);
    if (prev_hold && instr_valid) begin
      chk("hold_pc", instr_pc, prev_pc);
      chk("hold_data", instr_data, prev_data);
    end
    prev_hold = instr_valid && !ir && !redir && !rst;
    prev_pc   = instr_pc;
    prev_data = instr_data;
    pre_occ   = m_occ;
    if (rst) begin
      if (resp_now) void'(pending.pop_front());
      epoch++;
      m_occ = 0;
      expq.delete();
      m_fetch_pc = RESET_PC;
      m_resp_pc  = RESET_PC;
    end else begin
      if (resp_now) begin
        r = pending.pop_front();
        if (r.epoch == epoch && !redir) begin
          expq.push_back('{pc: m_resp_pc, data: memf(m_resp_pc)});
          m_resp_pc += 32'd4;
          m_occ++;
        end
      end
      if (pre_occ > 0 && ir && !redir) m_occ--;
      if (imem_req_valid && rdy) begin
        pending.push_back('{addr: imem_req_addr, due: cyc + lat, epoch: epoch});
        acc_log.push_back(imem_req_addr);
        m_fetch_pc += 32'd4;
        n_acc++;
      end
      if (redir) begin
        epoch++;
        m_occ = 0;
        expq.delete();
        m_fetch_pc = {tgt[31:2], 2'b00};
        m_resp_pc  = {tgt[31:2], 2'b00};
      end
    end
  endtask

  // Hold reset for n cycles, then until memory has answered everything in flight.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 50 && pending.size() > 0; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    if (pending.size() > 0) begin
      errors++;
      $display("FAIL reset_drain: %0d responses still pending", pending.size());
    end
    if (n >= 2) chk("reset_req_addr", imem_req_addr, RESET_PC);
    n_acc = 0;
    acc_log.delete();
  endtask

  // Step with instr_ready high until decode sees an instruction, then check it.
  task automatic expect_next(input string name, input logic [31:0] pc, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      found = instr_valid;
    end
    if (!found) begin
      errors++;
      $display("FAIL %s: no instr_valid within %0d cycles", name, budget);
    end else begin
      chk({name, "_pc"}, instr_pc, pc);
      chk({name, "_data"}, instr_data, memf(pc));
    end
  endtask

  // Scoreboard monitor: every consumed instruction must match the model's next entry.
  always @(negedge clk) begin
    if (!reset && !redirect_valid && instr_valid && instr_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h, expected no instruction", instr_pc);
      end else begin
        mon_e = expq.pop_front();
        chk("instr_pc", instr_pc, mon_e.pc);
        chk("instr_data", instr_data, mon_e.data);
      end
    end
  end

  // Protocol watch: memory must never answer when nothing is outstanding.
  always @(negedge clk) begin
    if (reset) begin
      ob_cnt = 0;
    end else begin
      if (imem_resp_valid) begin
        if (ob_cnt == 0) begin
          errors++;
          $display("FAIL protocol: response with 0 outstanding requests");
        end else begin
          ob_cnt--;
        end
      end
      if (imem_req_valid && imem_req_ready) ob_cnt++;
    end
  end

  initial begin
    int r;
    // Streaming from reset with 1-cycle memory: one instruction per cycle.
    lat = 1;
    do_reset(3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("stream_c3_valid", 32'(instr_valid), 32'd1);
    chk("stream_c3_pc", instr_pc, 32'h0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("stream_c4_pc", instr_pc, 32'h4);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("stream_c5_pc", instr_pc, 32'h8);

    // Decode stalled: exactly DEPTH requests, then fetch stops until a slot frees.
    do_reset(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("stall_requests", n_acc, 4);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_head_pc", instr_pc, 32'h0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("resume_req_valid", 32'(imem_req_valid), 32'd1);
    chk("resume_req_addr", imem_req_addr, 32'h10);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Latency 3, redirect with two requests in flight: both responses dropped.
    do_reset(2);
    lat = 3;
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    expect_next("redir100", 32'h100, 15);

    // Redirect coinciding with a response and a pop; target low bits ignored.
    lat = 1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h203, 1'b1, 1'b1);
    chk("redir203_valid_in_n", 32'(instr_valid), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("redir203_valid_n1", 32'(instr_valid), 32'd0);
    chk("redir203_req_addr", imem_req_addr, 32'h200);
    expect_next("redir203", 32'h200, 10);

    // Address wrap at the top of the 32-bit space.
    acc_log.delete();
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    if (acc_log.size() < 3) begin
      errors++;
      $display("FAIL wrap_count: got %0d requests, expected at least 3", acc_log.size());
    end else begin
      chk("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", acc_log[2], 32'h0000_0000);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Reset mid-stream with three requests outstanding; late responses ignored.
    do_reset(2);
    lat = 3;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    do_reset(3);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    if (acc_log.size() < 1) begin
      errors++;
      $display("FAIL rst_restart: got no request, expected one to %h", RESET_PC);
    end else begin
      chk("rst_restart_addr", acc_log[0], RESET_PC);
    end
    expect_next("rst_restart", RESET_PC, 10);

    // Random traffic: latency, jitter, ready patterns, redirects and resets.
    jitter = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) lat = $urandom_range(1, 4);
      r = $urandom_range(0, 999);
      if (r < 3) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step(1'b0, (r < 50), $urandom(), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0));
      end
    end

    // Drain: no new requests, everything expected must reach decode.
    jitter = 1'b0;
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("drain_expq_empty", expq.size(), 0);
    chk("drain_instr_valid", 32'(instr_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
